alu_issue_ctrl: RTL

- Sequential front end for the combinational `alu`. It accepts one decoded instruction per transaction over a valid/ready handshake and translates opcode/funct into the 4-bit ALU operation code.
- It registers the operands onto the ALU inputs, captures result and zero flag, and returns a write-back/branch response over a second valid/ready handshake.
- It sits between the decode stage and the register-file write-back / PC-select logic.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_op_decode.sv | 49 ++++
 rtl/alu_issue_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue front end: ALU op codes, MIPS-style
// opcode/funct values and the issue FSM state encoding.
package alu_pkg;

  // Bit3 selects the comparison path, bit2 the logic path.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_SLTIU = 6'b001011;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_XORI  = 6'b001110;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of opcode/funct into the ALU op code plus operand-b
// selection and branch/illegal tags.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       imm_sign,
  output logic       use_imm,
  output logic       is_beq,
  output logic       is_bne,
  output logic       illegal
);

  always_comb begin
    alu_op   = ALU_ADD;
    imm_sign = 1'b0;
    use_imm  = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_ADDI:  begin alu_op = ALU_ADD;  use_imm = 1'b1; imm_sign = 1'b1; end
      OPC_ANDI:  begin alu_op = ALU_AND;  use_imm = 1'b1; end
      OPC_ORI:   begin alu_op = ALU_OR;   use_imm = 1'b1; end
      OPC_XORI:  begin alu_op = ALU_XOR;  use_imm = 1'b1; end
      OPC_SLTI:  begin alu_op = ALU_SLT;  use_imm = 1'b1; imm_sign = 1'b1; end
      OPC_SLTIU: begin alu_op = ALU_SLTU; use_imm = 1'b1; imm_sign = 1'b1; end
      OPC_BEQ:   begin alu_op = ALU_SUB;  is_beq = 1'b1; end
      OPC_BNE:   begin alu_op = ALU_SUB;  is_bne = 1'b1; end
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue front end for the combinational ALU: accepts one decoded instruction,
// drives registered ALU inputs, captures the result and returns a response.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic [15:0]       imm16,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_flag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              branch_taken,
  output logic              illegal
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // in_ready is high only in IDLE, out_valid only in DONE, and the response
  // fields stay stable while out_valid is high and out_ready is low.

  state_e state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic beq_q, beq_d, bne_q, bne_d, ill_tag_q, ill_tag_d;
  logic zero_q, zero_d, branch_q, branch_d, illegal_q, illegal_d;

  logic [3:0] dec_op;
  logic dec_imm_sign, dec_use_imm, dec_beq, dec_bne, dec_illegal;
  logic [DATA_W-1:0] imm_ext, b_sel, exec_result;
  logic exec_zero;

  alu_op_decode u_dec (
    .opcode   (opcode),
    .funct    (funct),
    .alu_op   (dec_op),
    .imm_sign (dec_imm_sign),
    .use_imm  (dec_use_imm),
    .is_beq   (dec_beq),
    .is_bne   (dec_bne),
    .illegal  (dec_illegal)
  );

  always_comb begin
    imm_ext = dec_imm_sign ? {{(DATA_W-16){imm16[15]}}, imm16}
                           : {{(DATA_W-16){1'b0}}, imm16};
    b_sel   = dec_use_imm ? imm_ext : rt_val;
  end

  // alu_flag only covers the arithmetic/logic path, so comparisons test locally.
  always_comb begin
    exec_result = alu_result;
    exec_zero   = op_q[3] ? (alu_result == '0) : alu_flag;
    if (ill_tag_q) begin
      exec_result = '0;
      exec_zero   = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    beq_d     = beq_q;
    bne_d     = bne_q;
    ill_tag_d = ill_tag_q;
    result_d  = result_q;
    zero_d    = zero_q;
    branch_d  = branch_q;
    illegal_d = illegal_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d       = rs_val;
          b_d       = b_sel;
          op_d      = OP_W'(dec_op);
          beq_d     = dec_beq;
          bne_d     = dec_bne;
          ill_tag_d = dec_illegal;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d  = exec_result;
        zero_d    = exec_zero;
        branch_d  = (beq_q & exec_zero) | (bne_q & ~exec_zero);
        illegal_d = ill_tag_q;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_W'(ALU_ADD);
      beq_q     <= 1'b0;
      bne_q     <= 1'b0;
      ill_tag_q <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      beq_q     <= beq_d;
      bne_q     <= bne_d;
      ill_tag_q <= ill_tag_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      branch_q  <= branch_d;
      illegal_q <= illegal_d;
    end
  end

  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_op       = op_q;
  assign result       = result_q;
  assign zero         = zero_q;
  assign branch_taken = branch_q;
  assign illegal      = illegal_q;

endmodule
